// File: rtl/decode_pkg.sv
// Shared decode constants, ALU operation encoding and the control half of the ID/EX bundle.
package decode_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SLL = 3'd2,
        SLT = 3'd3,
        XOR = 3'd4,
        SRL = 3'd5,
        OR  = 3'd6,
        AND = 3'd7
    } alu_op_e;

    // Width-independent part of the decode bundle; operands live beside it in the stage.
    typedef struct packed {
        alu_op_e alu_op;
        logic    rd_we;
        logic    illegal;
    } decode_ctrl_t;

    // SUB and the func3=011 hole are resolved by the caller.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b001:  op = SLL;
            3'b010:  op = SLT;
            3'b100:  op = XOR;
            3'b101:  op = SRL;
            3'b110:  op = OR;
            3'b111:  op = AND;
            default: op = ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// Fetch-in, write-back and ID/EX-out signals of the decode stage; slave is the stage side.
interface decode_stage_p_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    import decode_pkg::*;

    localparam int RA_W = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            flush;
    logic            wb_en;
    logic [RA_W-1:0] wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    alu_op_e         alu_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] op2_data;
    logic [RA_W-1:0] rd_addr;
    logic            rd_we;
    logic            illegal;

    modport master (
        output in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, alu_op, rs1_data, op2_data, rd_addr, rd_we, illegal
    );

    modport slave (
        input  in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, alu_op, rs1_data, op2_data, rd_addr, rd_we, illegal
    );

endinterface

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one clocked write port; x0 is hard-wired to zero.
// A write in flight is forwarded to same-cycle reads so decode never sees stale data.
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RA_W = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] ra1,
    input  logic [RA_W-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : ((we && wa == ra1) ? wd : mem[ra1]);
    assign rd2 = (ra2 == '0) ? '0 : ((we && wa == ra2) ? wd : mem[ra2]);

endmodule

// File: rtl/decode_stage_p.sv
// ALU-instruction decode with register read, feeding a one-entry ID/EX register (1-cycle latency).
// Accepts when the register is empty or being drained; flush empties it and discards the incoming word.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IMM_W = 12
) (
    input logic             clk,
    input logic             rst,
    decode_stage_p_if.slave bus
);

    localparam int RA_W = $clog2(NREGS);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [RA_W-1:0] rs1_idx;
    logic [RA_W-1:0] rs2_idx;
    logic [RA_W-1:0] rd_idx;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_rd;
    logic [XLEN-1:0] rs2_rd;

    assign opcode  = bus.instr[6:0];
    assign f3      = bus.instr[14:12];
    assign f7      = bus.instr[31:25];
    assign rd_idx  = bus.instr[7 +: RA_W];
    assign rs1_idx = bus.instr[15 +: RA_W];
    assign rs2_idx = bus.instr[20 +: RA_W];
    assign imm     = {{(XLEN-IMM_W){bus.instr[31]}}, bus.instr[20 +: IMM_W]};

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_idx),
        .ra2 (rs2_idx),
        .rd1 (rs1_rd),
        .rd2 (rs2_rd),
        .we  (bus.wb_en),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

    logic         legal;
    alu_op_e      dec_op;
    decode_ctrl_t dec_ctrl;

    always_comb begin
        legal  = 1'b0;
        dec_op = ADD;
        case (opcode)
            OPC_RTYPE: begin
                if (f3 == 3'b000 && f7 == F7_ALT) begin
                    legal  = 1'b1;
                    dec_op = SUB;
                end else if (f7 == F7_BASE && f3 != 3'b011) begin
                    legal  = 1'b1;
                    dec_op = f3_to_op(f3);
                end
            end
            OPC_ITYPE: begin
                // Only the shift immediates reuse the top bits as func7; elsewhere they are immediate.
                if (f3 != 3'b011 && !(f3[1:0] == 2'b01 && f7 != F7_BASE)) begin
                    legal  = 1'b1;
                    dec_op = f3_to_op(f3);
                end
            end
            default: ;
        endcase
        dec_ctrl.alu_op  = dec_op;
        dec_ctrl.rd_we   = legal && (rd_idx != '0);
        dec_ctrl.illegal = !legal;
    end

    logic            valid_q;
    decode_ctrl_t    ctrl_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] op2_q;
    logic [RA_W-1:0] rd_q;
    logic            in_ready;
    logic            accept;

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (accept && !bus.flush) begin
                ctrl_q <= dec_ctrl;
                rs1_q  <= rs1_rd;
                op2_q  <= (opcode == OPC_RTYPE) ? rs2_rd : imm;
                rd_q   <= rd_idx;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.alu_op    = ctrl_q.alu_op;
    assign bus.rd_we     = ctrl_q.rd_we;
    assign bus.illegal   = ctrl_q.illegal;
    assign bus.rs1_data  = rs1_q;
    assign bus.op2_data  = op2_q;
    assign bus.rd_addr   = rd_q;

endmodule
